multdiv_sequencer: RTL and testbench

//  Sequences the shared multicycle multiply/divide unit for R-type mul/div (opcode 00000, ALU op 00110/00111).

---
 rtl/multdiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_sequencer
//  Purpose  : Launches the shared multicycle mul/div unit, stalls execute until
//             result or timeout, then issues a one-cycle rd or $rstatus write.
//  Revision : 1.0
// ============================================================================
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 34,
    parameter int CNT_W      = 6,
    parameter int MUL_EXC    = 5,
    parameter int DIV_EXC    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       opcode,
    input  logic [4:0]       alu_op,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    input  logic             md_ready,
    input  logic             md_exception,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             stall,
    output logic             busy,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic             wb_rstatus_en,
    output logic [31:0]      rstatus_val,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [4:0]       c_OPC_RTYPE = 5'b00000;
    localparam logic [4:0]       c_ALU_MUL   = 5'b00110;
    localparam logic [4:0]       c_ALU_DIV   = 5'b00111;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      c_MUL_CODE  = 32'(MUL_EXC);
    localparam logic [31:0]      c_DIV_CODE  = 32'(DIV_EXC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_is_div;
    logic [4:0]         r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ctrl_mult;
    logic               r_ctrl_div;
    logic               r_wb_en;
    logic               r_wb_rstatus_en;
    logic [31:0]        r_rstatus_val;

    logic               w_is_md;
    logic               w_accept;

    assign w_is_md  = issue_valid && (opcode == c_OPC_RTYPE) &&
                      ((alu_op == c_ALU_MUL) || (alu_op == c_ALU_DIV));
    assign w_accept = w_is_md && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_is_div        <= 1'b0;
            r_rd            <= '0;
            r_cnt           <= '0;
            r_ctrl_mult     <= 1'b0;
            r_ctrl_div      <= 1'b0;
            r_wb_en         <= 1'b0;
            r_wb_rstatus_en <= 1'b0;
            r_rstatus_val   <= '0;
        end else begin
            // Pulsed outputs default low; only a state transition raises them.
            r_ctrl_mult     <= 1'b0;
            r_ctrl_div      <= 1'b0;
            r_wb_en         <= 1'b0;
            r_wb_rstatus_en <= 1'b0;
            r_rstatus_val   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div    <= alu_op[0];
                        r_rd        <= rd_in;
                        r_ctrl_mult <= !alu_op[0];
                        r_ctrl_div  <= alu_op[0];
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (md_ready) begin
                        r_state <= S_DONE;
                        if (md_exception) begin
                            r_wb_rstatus_en <= 1'b1;
                            r_rstatus_val   <= r_is_div ? c_DIV_CODE : c_MUL_CODE;
                        end else begin
                            r_wb_en <= 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Timeout is always reported with the divide code.
                        r_state         <= S_DONE;
                        r_wb_rstatus_en <= 1'b1;
                        r_rstatus_val   <= c_DIV_CODE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The IDLE-side stall must act in the issue cycle, so it is combinational.
    assign stall = !reset && (((r_state == S_IDLE) && w_accept) ||
                              (r_state == S_START) || (r_state == S_WAIT));

    assign busy          = (r_state != S_IDLE);
    assign ctrl_mult     = r_ctrl_mult;
    assign ctrl_div      = r_ctrl_div;
    assign wb_en         = r_wb_en;
    assign wb_rd         = r_rd;
    assign wb_rstatus_en = r_wb_rstatus_en;
    assign rstatus_val   = r_rstatus_val;
    assign cycle_count   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_sequencer
//  Purpose  : Self-checking bench; expected timeline per op comes from a
//             transaction-level model of the sequencing rules.
//  Revision : 1.0
// ============================================================================
module tb_multdiv_sequencer;

    localparam int MAX_CYCLES = 34;
    localparam int CNT_W      = 6;
    localparam int MUL_EXC    = 5;
    localparam int DIV_EXC    = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic [4:0]       opcode;
    logic [4:0]       alu_op;
    logic [4:0]       rd_in;
    logic             flush;
    logic             md_ready;
    logic             md_exception;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             stall;
    logic             busy;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic             wb_rstatus_en;
    logic [31:0]      rstatus_val;
    logic [CNT_W-1:0] cycle_count;

    int errors = 0;
    int checks = 0;

    multdiv_sequencer #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W),
        .MUL_EXC    (MUL_EXC),
        .DIV_EXC    (DIV_EXC)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .opcode        (opcode),
        .alu_op        (alu_op),
        .rd_in         (rd_in),
        .flush         (flush),
        .md_ready      (md_ready),
        .md_exception  (md_exception),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .stall         (stall),
        .busy          (busy),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_rstatus_en (wb_rstatus_en),
        .rstatus_val   (rstatus_val),
        .cycle_count   (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        opcode       = 5'b00000;
        alu_op       = 5'b00000;
        rd_in        = 5'd0;
        flush        = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
    endtask

    // One mul/div transaction. ready_at / flush_at are WAIT-cycle indices, -1 = never.
    task automatic run_op(input bit is_div, input logic [4:0] rd, input int ready_at,
                          input bit exc, input int flush_at);
        int  e;
        bit  flushed;
        bit  timeout;
        bit  exp_wb;
        logic [31:0] exp_val;

        e = MAX_CYCLES - 1;
        if (ready_at >= 0 && ready_at < e) e = ready_at;
        if (flush_at >= 0 && flush_at <= e) e = flush_at;
        flushed = (flush_at == e);
        timeout = !flushed && (ready_at != e);
        exp_wb  = !flushed && !timeout && !exc;
        exp_val = (flushed || exp_wb) ? 32'd0 :
                  (timeout ? DIV_EXC : (is_div ? DIV_EXC : MUL_EXC));

        // Issue cycle
        issue_valid = 1'b1;
        opcode      = 5'b00000;
        alu_op      = is_div ? 5'b00111 : 5'b00110;
        rd_in       = rd;
        flush       = 1'b0;
        md_ready    = 1'b0;
        settle();
        check_val("issue_stall", stall, 1);
        check_val("issue_busy", busy, 0);

        // START: md_ready here must be ignored
        next_cycle();
        idle_inputs();
        md_ready     = 1'($urandom_range(0, 1));
        md_exception = 1'($urandom_range(0, 1));
        settle();
        check_val("start_mult", ctrl_mult, !is_div);
        check_val("start_div", ctrl_div, is_div);
        check_val("start_stall", stall, 1);
        check_val("start_busy", busy, 1);

        for (int k = 0; k <= e; k++) begin
            next_cycle();
            idle_inputs();
            flush        = (k == flush_at);
            md_ready     = (k == ready_at);
            md_exception = (k == ready_at) ? exc : 1'($urandom_range(0, 1));
            settle();
            check_val("wait_stall", stall, 1);
            check_val("wait_count", cycle_count, k);
            check_val("wait_pulses", {ctrl_mult, ctrl_div, wb_en, wb_rstatus_en}, 0);
        end

        next_cycle();
        idle_inputs();
        if (flushed) begin
            settle();
            check_val("flush_busy", busy, 0);
            check_val("flush_wb", {wb_en, wb_rstatus_en}, 0);
        end else begin
            // A new mul/div presented in DONE must not be accepted
            issue_valid = 1'b1;
            alu_op      = 5'b00110 | 5'($urandom_range(0, 1));
            rd_in       = 5'($urandom_range(0, 31));
            settle();
            check_val("done_stall", stall, 0);
            check_val("done_busy", busy, 1);
            check_val("done_wb_en", wb_en, exp_wb);
            check_val("done_rs_en", wb_rstatus_en, !exp_wb);
            check_val("done_rs_val", rstatus_val, exp_val);
            check_val("done_count", cycle_count, e + 1);
            check_val("done_pulses", {ctrl_mult, ctrl_div}, 0);
            if (exp_wb) check_val("done_wb_rd", wb_rd, rd);
            next_cycle();
            idle_inputs();
            settle();
            check_val("post_done_busy", busy, 0);
            check_val("post_done_wb", {wb_en, wb_rstatus_en}, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        settle();
        check_val("rst_busy", busy, 0);
        check_val("rst_stall", stall, 0);
        check_val("rst_pulses", {ctrl_mult, ctrl_div, wb_en, wb_rstatus_en}, 0);
        check_val("rst_rd", wb_rd, 0);
        check_val("rst_val", rstatus_val, 0);
        check_val("rst_count", cycle_count, 0);
        next_cycle();
        reset = 1'b0;

        // Directed cases
        run_op(1'b0, 5'd7, 5, 1'b0, -1);          // mul, clean result
        run_op(1'b1, 5'd3, 4, 1'b1, -1);          // div by zero
        run_op(1'b0, 5'd9, 2, 1'b1, -1);          // mul overflow
        run_op(1'b1, 5'd12, -1, 1'b0, -1);        // timeout
        run_op(1'b0, 5'd4, 6, 1'b0, 6);           // flush beats md_ready
        run_op(1'b0, 5'd1, 0, 1'b0, -1);          // back-to-back, min latency
        run_op(1'b1, 5'd2, 3, 1'b0, -1);
        run_op(1'b0, 5'd30, MAX_CYCLES - 1, 1'b0, -1); // ready on the last allowed cycle

        // Non-md instructions never stall
        issue_valid = 1'b1; opcode = 5'b00000; alu_op = 5'b00000; rd_in = 5'd5;
        settle();
        check_val("rtype_stall", stall, 0);
        next_cycle();
        opcode = 5'b00101; alu_op = 5'b00110;
        settle();
        check_val("rtype_busy", busy, 0);
        check_val("addi_stall", stall, 0);
        next_cycle();
        opcode = 5'b00000; alu_op = 5'b00111; flush = 1'b1;
        settle();
        check_val("addi_busy", busy, 0);
        check_val("flush_issue_stall", stall, 0);
        next_cycle();
        idle_inputs();
        alu_op = 5'b00110;
        settle();
        check_val("flush_issue_busy", busy, 0);
        check_val("novalid_stall", stall, 0);
        next_cycle();
        idle_inputs();
        settle();
        check_val("novalid_busy", busy, 0);

        // Reset held 2 cycles in the middle of WAIT
        next_cycle();
        issue_valid = 1'b1; alu_op = 5'b00111; rd_in = 5'd21;
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
        settle();
        check_val("pre_rst_busy", busy, 1);
        reset    = 1'b1;
        md_ready = 1'b1;
        next_cycle();
        settle();
        check_val("midrst_busy", busy, 0);
        check_val("midrst_stall", stall, 0);
        check_val("midrst_pulses", {ctrl_mult, ctrl_div, wb_en, wb_rstatus_en}, 0);
        check_val("midrst_count", cycle_count, 0);
        check_val("midrst_rd", wb_rd, 0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < MAX_CYCLES + 4; i++) begin
            next_cycle();
            settle();
            check_val("post_rst_quiet", {busy, wb_en, wb_rstatus_en}, 0);
        end

        // Randomized transactions with random idle gaps
        for (int n = 0; n < 40; n++) begin
            int gap;
            int fl;
            fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_CYCLES + 1)) : -1;
            run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, MAX_CYCLES + 6)), 1'($urandom_range(0, 1)), fl);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
